// File: rtl/divider_param_pkg.sv
// Shared encodings for the parameterised restoring divider:
// FSM state codes and the signed/unsigned mode select.
package divider_param_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BYZERO = 2'b01,
        ON     = 2'b10,
        END    = 2'b11
    } divState_t;

    typedef enum logic {
        DIVU = 1'b0,
        DIV  = 1'b1
    } divMode_t;

endpackage

// File: rtl/divider_param_if.sv
// Request/response bundle between the pipeline (master) and the divider (slave).
interface divider_param_if #(parameter int WIDTH = 32);

    logic                 start_i;
    logic                 signed_i;
    logic                 annul_i;
    logic [WIDTH-1:0]     opdata1_i;
    logic [WIDTH-1:0]     opdata2_i;
    logic [2*WIDTH-1:0]   result_o;
    logic                 ready_o;
    logic                 busy_o;
    logic                 div_zero_o;

    modport master (
        output start_i, signed_i, annul_i, opdata1_i, opdata2_i,
        input  result_o, ready_o, busy_o, div_zero_o
    );

    modport slave (
        input  start_i, signed_i, annul_i, opdata1_i, opdata2_i,
        output result_o, ready_o, busy_o, div_zero_o
    );

endinterface

// File: rtl/divider_param_div_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// trial-subtract the divisor, keep or restore, and shift in the quotient bit.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] remIn,
    input  logic [WIDTH-1:0] quoIn,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] remOut,
    output logic [WIDTH-1:0] quoOut
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // remIn < divisor always holds, so bit WIDTH of trial is a clean borrow flag
    always_comb begin
        shifted = {remIn, quoIn[WIDTH-1]};
        trial   = shifted - {1'b0, divisor};
        if (trial[WIDTH]) begin
            remOut = shifted[WIDTH-1:0];
            quoOut = {quoIn[WIDTH-2:0], 1'b0};
        end else begin
            remOut = trial[WIDTH-1:0];
            quoOut = {quoIn[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/divider_param.sv
// Multi-cycle signed/unsigned restoring divider with divide-by-zero and
// early-out paths; result is {remainder, quotient}.
module divider_param
    import divider_param_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int EARLY_OUT = 1
) (
    input  logic            clk,
    input  logic            rst,
    divider_param_if.slave  bus
);

    localparam int CW = $clog2(WIDTH) + 1;

    divState_t          state, stateNext;
    logic [CW-1:0]      cnt, cntNext;
    logic [WIDTH-1:0]   dividendReg, dividendNext;
    logic [WIDTH-1:0]   divisorMag, divisorNext;
    logic [WIDTH-1:0]   remReg, remNext;
    logic [WIDTH-1:0]   quoReg, quoNext;
    logic               negQuo, negQuoNext;
    logic               negRem, negRemNext;
    logic [2*WIDTH-1:0] resultReg, resultNext;
    logic               readyReg, readyNext;
    logic               divZeroReg, divZeroNext;

    logic               isSigned, signA, signB;
    logic [WIDTH-1:0]   absA, absB;
    logic [WIDTH-1:0]   stepRem, stepQuo, fixQuo, fixRem;

    div_step #(.WIDTH(WIDTH)) u_step (
        .remIn   (remReg),
        .quoIn   (quoReg),
        .divisor (divisorMag),
        .remOut  (stepRem),
        .quoOut  (stepQuo)
    );

    // Magnitudes of the live inputs and sign fix-up of the final step output
    always_comb begin
        isSigned = (divMode_t'(bus.signed_i) == DIV);
        signA    = isSigned & bus.opdata1_i[WIDTH-1];
        signB    = isSigned & bus.opdata2_i[WIDTH-1];
        absA     = signA ? (~bus.opdata1_i + WIDTH'(1)) : bus.opdata1_i;
        absB     = signB ? (~bus.opdata2_i + WIDTH'(1)) : bus.opdata2_i;
        fixQuo   = (negQuo && stepQuo != '0) ? (~stepQuo + WIDTH'(1)) : stepQuo;
        fixRem   = (negRem && stepRem != '0) ? (~stepRem + WIDTH'(1)) : stepRem;
    end

    always_comb begin
        stateNext    = state;
        cntNext      = cnt;
        dividendNext = dividendReg;
        divisorNext  = divisorMag;
        remNext      = remReg;
        quoNext      = quoReg;
        negQuoNext   = negQuo;
        negRemNext   = negRem;
        resultNext   = '0;
        readyNext    = 1'b0;
        divZeroNext  = 1'b0;

        case (state)
            IDLE: begin
                if (bus.start_i) begin
                    dividendNext = bus.opdata1_i;
                    divisorNext  = absB;
                    remNext      = '0;
                    quoNext      = absA;
                    negQuoNext   = signA ^ signB;
                    negRemNext   = signA;
                    cntNext      = '0;
                    if (bus.opdata2_i == '0) begin
                        stateNext = BYZERO;
                    end else if (EARLY_OUT != 0 && absA < absB) begin
                        stateNext  = END;
                        readyNext  = 1'b1;
                        resultNext = {bus.opdata1_i, {WIDTH{1'b0}}};
                    end else begin
                        stateNext = ON;
                    end
                end
            end
            BYZERO: begin
                stateNext   = END;
                readyNext   = 1'b1;
                divZeroNext = 1'b1;
                resultNext  = {dividendReg, {WIDTH{1'b1}}};
            end
            ON: begin
                remNext = stepRem;
                quoNext = stepQuo;
                cntNext = cnt + 1'b1;
                // final step retires straight into END with the signed result
                if (cnt == CW'(WIDTH - 1)) begin
                    stateNext  = END;
                    readyNext  = 1'b1;
                    resultNext = {fixRem, fixQuo};
                end
            end
            END: begin
                if (bus.start_i) begin
                    readyNext   = readyReg;
                    resultNext  = resultReg;
                    divZeroNext = divZeroReg;
                end else begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase

        if (bus.annul_i) begin
            stateNext   = IDLE;
            readyNext   = 1'b0;
            resultNext  = '0;
            divZeroNext = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            dividendReg <= '0;
            divisorMag  <= '0;
            remReg      <= '0;
            quoReg      <= '0;
            negQuo      <= 1'b0;
            negRem      <= 1'b0;
            resultReg   <= '0;
            readyReg    <= 1'b0;
            divZeroReg  <= 1'b0;
        end else begin
            state       <= stateNext;
            cnt         <= cntNext;
            dividendReg <= dividendNext;
            divisorMag  <= divisorNext;
            remReg      <= remNext;
            quoReg      <= quoNext;
            negQuo      <= negQuoNext;
            negRem      <= negRemNext;
            resultReg   <= resultNext;
            readyReg    <= readyNext;
            divZeroReg  <= divZeroNext;
        end
    end

    assign bus.result_o   = resultReg;
    assign bus.ready_o    = readyReg;
    assign bus.div_zero_o = divZeroReg;
    assign bus.busy_o     = (state == ON) || (state == BYZERO);

endmodule

// File: tb/tb_divider_param.sv
// Directed bench for divider_param: 32-bit with and without early-out, and 8-bit.
module tb_divider_param;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    divider_param_if #(.WIDTH(32)) bA ();
    divider_param_if #(.WIDTH(32)) bN ();
    divider_param_if #(.WIDTH(8))  b8 ();

    divider_param #(.WIDTH(32), .EARLY_OUT(1)) dutA (.clk(clk), .rst(rst), .bus(bA));
    divider_param #(.WIDTH(32), .EARLY_OUT(0)) dutN (.clk(clk), .rst(rst), .bus(bN));
    divider_param #(.WIDTH(8),  .EARLY_OUT(1)) dut8 (.clk(clk), .rst(rst), .bus(b8));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int sel, input logic st, input logic sg,
                         input logic [63:0] a, input logic [63:0] b);
        case (sel)
            0:       begin bA.start_i = st; bA.signed_i = sg; bA.opdata1_i = a[31:0]; bA.opdata2_i = b[31:0]; end
            1:       begin bN.start_i = st; bN.signed_i = sg; bN.opdata1_i = a[31:0]; bN.opdata2_i = b[31:0]; end
            default: begin b8.start_i = st; b8.signed_i = sg; b8.opdata1_i = a[7:0];  b8.opdata2_i = b[7:0];  end
        endcase
    endtask

    task automatic setStart(input int sel, input logic st);
        case (sel)
            0:       bA.start_i = st;
            1:       bN.start_i = st;
            default: b8.start_i = st;
        endcase
    endtask

    function automatic logic [63:0] resOf(input int sel);
        case (sel)
            0:       return bA.result_o;
            1:       return bN.result_o;
            default: return {48'b0, b8.result_o};
        endcase
    endfunction

    function automatic logic readyOf(input int sel);
        case (sel)
            0:       return bA.ready_o;
            1:       return bN.ready_o;
            default: return b8.ready_o;
        endcase
    endfunction

    function automatic logic zeroOf(input int sel);
        case (sel)
            0:       return bA.div_zero_o;
            1:       return bN.div_zero_o;
            default: return b8.div_zero_o;
        endcase
    endfunction

    // k0 = edges already elapsed since start_i was raised
    task automatic waitReady(input int sel, input int k0, input int lat,
                             input logic [63:0] res, input logic z, input string tag);
        int k;
        k = k0;
        do begin
            tick();
            k++;
        end while (!readyOf(sel) && k < 100);
        check({tag, " latency"}, 64'(k), 64'(lat));
        check({tag, " result"}, resOf(sel), res);
        check({tag, " div_zero"}, 64'(zeroOf(sel)), 64'(z));
        repeat (2) tick();
        check({tag, " hold ready"}, 64'(readyOf(sel)), 64'd1);
        check({tag, " hold result"}, resOf(sel), res);
        setStart(sel, 1'b0);
        tick();
        check({tag, " drop ready"}, 64'(readyOf(sel)), 64'd0);
        check({tag, " drop result"}, resOf(sel), 64'd0);
    endtask

    task automatic run(input int sel, input logic sg, input logic [63:0] a, input logic [63:0] b,
                       input int lat, input logic [63:0] res, input logic z, input string tag);
        drive(sel, 1'b1, sg, a, b);
        waitReady(sel, 0, lat, res, z, tag);
    endtask

    initial begin
        rst = 1'b0;
        drive(0, 1'b0, 1'b0, 64'd0, 64'd0);
        drive(1, 1'b0, 1'b0, 64'd0, 64'd0);
        drive(2, 1'b0, 1'b0, 64'd0, 64'd0);
        bA.annul_i = 1'b0;
        bN.annul_i = 1'b0;
        b8.annul_i = 1'b0;

        tick();
        tick();
        check("reset ready",   64'(bA.ready_o), 64'd0);
        check("reset busy",    64'(bA.busy_o), 64'd0);
        check("reset result",  bA.result_o, 64'd0);
        check("reset divzero", 64'(bA.div_zero_o), 64'd0);
        check("reset ready8",  64'(b8.ready_o), 64'd0);
        rst = 1'b1;
        tick();

        run(0, 1'b0, 64'd100, 64'd7, 33, 64'h00000002_0000000E, 1'b0, "u100/7");
        run(0, 1'b1, 64'hFFFFFFF9, 64'd2, 33, 64'hFFFFFFFF_FFFFFFFD, 1'b0, "s-7/2");
        run(0, 1'b1, 64'h80000000, 64'hFFFFFFFF, 33, 64'h00000000_80000000, 1'b0, "sMinNeg/-1");
        run(0, 1'b0, 64'h1234, 64'd0, 2, 64'h00001234_FFFFFFFF, 1'b1, "u/zero");
        run(0, 1'b1, 64'hFFFFFFFB, 64'd0, 2, 64'hFFFFFFFB_FFFFFFFF, 1'b1, "s-5/zero");
        run(0, 1'b0, 64'd3, 64'd10, 1, 64'h00000003_00000000, 1'b0, "early3/10");
        run(0, 1'b1, 64'hFFFFFFFD, 64'd10, 1, 64'hFFFFFFFD_00000000, 1'b0, "early-3/10");
        run(0, 1'b1, 64'd7, 64'hFFFFFFFE, 33, 64'h00000001_FFFFFFFD, 1'b0, "s7/-2");
        run(0, 1'b1, 64'hFFFFFFFA, 64'd3, 33, 64'h00000000_FFFFFFFE, 1'b0, "s-6/3");
        run(0, 1'b0, 64'hFFFFFFFF, 64'd1, 33, 64'h00000000_FFFFFFFF, 1'b0, "uMax/1");
        run(0, 1'b0, 64'hFFFFFFFF, 64'hFFFFFFFF, 33, 64'h00000000_00000001, 1'b0, "uMax/Max");
        run(1, 1'b0, 64'd3, 64'd10, 33, 64'h00000003_00000000, 1'b0, "noEarly3/10");

        // operands and mode changed mid-operation must not disturb the result
        drive(0, 1'b1, 1'b0, 64'd100, 64'd7);
        repeat (5) tick();
        check("chg busy", 64'(bA.busy_o), 64'd1);
        drive(0, 1'b1, 1'b1, 64'hFFFFFFF7, 64'd5);
        waitReady(0, 5, 33, 64'h00000002_0000000E, 1'b0, "chgOps");

        // annul at T+10
        drive(0, 1'b1, 1'b0, 64'd100, 64'd7);
        repeat (10) tick();
        check("annul ready pre", 64'(bA.ready_o), 64'd0);
        bA.annul_i = 1'b1;
        setStart(0, 1'b0);
        tick();
        check("annul busy",   64'(bA.busy_o), 64'd0);
        check("annul ready",  64'(bA.ready_o), 64'd0);
        check("annul result", bA.result_o, 64'd0);
        bA.annul_i = 1'b0;
        tick();
        check("annul idle ready", 64'(bA.ready_o), 64'd0);
        run(0, 1'b0, 64'd1000, 64'd10, 33, 64'h00000000_00000064, 1'b0, "afterAnnul");

        // annul wins over start in the same cycle
        bA.annul_i = 1'b1;
        drive(0, 1'b1, 1'b0, 64'd100, 64'd7);
        tick();
        check("annulPrio busy", 64'(bA.busy_o), 64'd0);
        bA.annul_i = 1'b0;
        waitReady(0, 0, 33, 64'h00000002_0000000E, 1'b0, "annulPrio");

        // reset while a result is presented clears outputs immediately
        drive(0, 1'b1, 1'b0, 64'd3, 64'd10);
        tick();
        check("rstEnd ready pre", 64'(bA.ready_o), 64'd1);
        #2 rst = 1'b0;
        #1;
        check("rstEnd ready",  64'(bA.ready_o), 64'd0);
        check("rstEnd result", bA.result_o, 64'd0);
        rst = 1'b1;
        setStart(0, 1'b0);
        tick();

        // reset at T+5 mid-operation, then start held through deassertion
        drive(0, 1'b1, 1'b0, 64'd50, 64'd3);
        repeat (5) tick();
        #2 rst = 1'b0;
        #1;
        check("rstMid busy",    64'(bA.busy_o), 64'd0);
        check("rstMid ready",   64'(bA.ready_o), 64'd0);
        check("rstMid result",  bA.result_o, 64'd0);
        check("rstMid divzero", 64'(bA.div_zero_o), 64'd0);
        drive(0, 1'b1, 1'b0, 64'd100, 64'd7);
        @(negedge clk);
        rst = 1'b1;
        waitReady(0, 0, 33, 64'h00000002_0000000E, 1'b0, "afterRst");

        run(2, 1'b0, 64'd200, 64'd7, 9, 64'h041C, 1'b0, "w8 200/7");
        run(2, 1'b1, 64'h80, 64'hFF, 9, 64'h0080, 1'b0, "w8 minNeg/-1");
        run(2, 1'b0, 64'd5, 64'd0, 2, 64'h05FF, 1'b1, "w8 5/zero");
        run(2, 1'b1, 64'h9C, 64'd7, 9, 64'hFEF2, 1'b0, "w8 -100/7");
        run(2, 1'b0, 64'd3, 64'd10, 1, 64'h0300, 1'b0, "w8 early3/10");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/divider_param.md
DIVIDER_PARAM -- requirements
Module: divider_param

Interface
REQ-001 SHALL expose parameter WIDTH, default 32: operand width in bits, legal range 8..64.
REQ-002 SHALL expose parameter EARLY_OUT, default 1: 1 enables the short path for |dividend| < |divisor|.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 start_i  input  1  request a division; level-held by the pipeline until the result is taken.
REQ-006 signed_i  input  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start_i.
REQ-007 annul_i  input  1  cancel the current or pending operation (pipeline flush).
REQ-008 opdata1_i  input  WIDTH  dividend.
REQ-009 opdata2_i  input  WIDTH  divisor.
REQ-010 result_o  output  2*WIDTH  {remainder, quotient}: upper half to HI, lower half to LO.
REQ-011 ready_o  output  1  result_o is valid.
REQ-012 busy_o  output  1  an operation is in progress (state ON or BYZERO).
REQ-013 div_zero_o  output  1  the completed operation had a zero divisor; valid while ready_o=1.

Function
REQ-014 SHALL implement the states IDLE, BYZERO, ON and END.
REQ-015 In IDLE, with start_i=1 and annul_i=0, the block SHALL latch the operands and signed_i at cycle T.
REQ-016 From IDLE, a zero divisor SHALL go to BYZERO.
REQ-017 From IDLE, with EARLY_OUT=1 and |dividend| < |divisor|, the block SHALL go directly to END.
REQ-018 From IDLE, all other accepted requests SHALL go to ON.
REQ-019 ON SHALL run exactly WIDTH restoring-division steps on the operand magnitudes, one step per cycle, using a cnt register of width clog2(WIDTH)+1.
REQ-020 Normal path: ready_o SHALL rise at cycle T+WIDTH+1.
REQ-021 BYZERO path: ready_o SHALL rise at T+2.
REQ-022 Early-out path: ready_o SHALL rise at T+1.
REQ-023 BYZERO result: quotient = all ones, remainder = dividend, div_zero_o=1.
REQ-024 Early-out result: quotient = 0, remainder = dividend (original signed value).
REQ-025 Signed mode: quotient sign = sign(dividend) XOR sign(divisor); remainder sign = sign of dividend; a zero result SHALL NOT be negated.
REQ-026 Signed mode with most-negative dividend / -1: quotient = most-negative value (wraps), remainder = 0, no flag.
REQ-027 Operands SHALL be captured only at acceptance; later changes to opdata*_i and signed_i have no effect.
REQ-028 END SHALL hold ready_o=1 and result_o stable while start_i=1.
REQ-029 END with start_i=0 SHALL go to IDLE next cycle, with ready_o=0 in that cycle.
REQ-030 start_i=1 while in ON or BYZERO SHALL be ignored: no restart, no re-latch.
REQ-031 annul_i=1 in any state SHALL force IDLE next cycle, with ready_o=0, result_o=0 and div_zero_o=0.
REQ-032 annul_i=1 SHALL take priority over start_i in the same cycle; a new request is accepted no earlier than the following cycle.
REQ-033 result_o SHALL be 0 whenever ready_o=0.
REQ-034 busy_o SHALL be combinational from state.
REQ-035 ready_o, result_o and div_zero_o SHALL be registered.

Reset
REQ-036 rst low SHALL asynchronously force state=IDLE, cnt=0, result_o=0, ready_o=0, busy_o=0 and div_zero_o=0.
REQ-037 Reset asserted mid-operation SHALL discard the operation without producing a result.
REQ-038 After rst deasserts, a start_i already held high SHALL be accepted on the first rising edge.

Structure
REQ-039 A shared package SHALL hold the state encoding (IDLE=2'b00, BYZERO=2'b01, ON=2'b10, END=2'b11) and the divider control codes that select signed and unsigned mode.
REQ-040 One sub-module, div_step, SHALL implement a single combinational restoring step (partial remainder shift/subtract, quotient bit), parameterised by WIDTH.
REQ-041 Magnitude conversion and sign fix-up SHALL be done inline.

Verification
REQ-042 Benches SHALL cover WIDTH=32 and WIDTH=8.
REQ-043 WIDTH=32, unsigned 100/7, start_i held -> ready_o at T+33, result_o={32'd2, 32'd14}; ready_o held until start_i drops, then low one cycle later.
REQ-044 Signed -7/2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
REQ-045 Signed 0x80000000/0xFFFFFFFF -> quotient 0x80000000, remainder 0, div_zero_o=0.
REQ-046 Unsigned 0x1234/0 -> ready_o at T+2, quotient 0xFFFFFFFF, remainder 0x1234, div_zero_o=1.
REQ-047 EARLY_OUT=1, unsigned 3/10 -> ready_o at T+1, {3, 0}.
REQ-048 EARLY_OUT=0 with the same 3/10 operands -> ready_o at T+33 with the same result.
REQ-049 annul_i pulsed at T+10 of a 32-bit operation -> IDLE at T+11, ready_o never rises; a new request at T+12 completes normally.
REQ-050 rst pulsed low at T+5 mid-operation -> all outputs 0 immediately.
REQ-051 Operand inputs changed while in ON -> the original result is unchanged.
